// File: rtl/mem_arbiter.sv
// mem_arbiter -- shares one single-ported, byte-addressed unified memory
// between the instruction-fetch port (if_*) and the data load/store port (d_*).
//
// Optional feature macro: MEM_ARB_FAIRNESS_EN
//   undefined : fixed data priority (fetch may starve under continuous d_req)
//   defined   : after MAX_DATA_RUN consecutive data grants with fetch waiting,
//               fetch wins the next arbitration
//
// Ports:
//   clock, reset          : rising-edge clock, synchronous active-high reset
//   if_req/if_addr        : fetch request (held until if_gnt) and byte address
//   if_gnt                : one-cycle fetch grant (address captured on this edge)
//   if_rvalid/if_rdata    : one-cycle fetch response pulse and instruction word
//   d_req/d_we/d_addr/d_wdata : data request, store flag, byte address, store data
//   d_gnt                 : one-cycle data grant
//   d_rvalid/d_rdata      : one-cycle data response; for stores, pre-write contents
//   mem_addr/mem_wen/mem_wdata : memory address, write enable, write data
//   mem_rdata             : combinational memory read of mem_addr
//
// Timing: grant in cycle N, memory access in N+1, rvalid in N+2. The RESP
// cycle also arbitrates, giving one access every 2 cycles back-to-back.
module mem_arbiter #(
   parameter int unsigned ADDR_W       = 32,
   parameter int unsigned DATA_W       = 32,
   parameter int unsigned MAX_DATA_RUN = 4
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_gnt,
   output logic              if_rvalid,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_gnt,
   output logic              d_rvalid,
   output logic [DATA_W-1:0] d_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_wen,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              we_q, we_d;
   logic              sel_d_q, sel_d_d;      // 1: current access belongs to data port
   logic              if_rvalid_q, if_rvalid_d;
   logic              d_rvalid_q, d_rvalid_d;
   logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
   logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
   logic              grant_if, grant_d;
   logic              fetch_first;
`ifdef MEM_ARB_FAIRNESS_EN
   logic [3:0]        run_cnt_q, run_cnt_d;
`endif

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      we_d        = we_q;
      sel_d_d     = sel_d_q;
      if_rvalid_d = 1'b0;
      d_rvalid_d  = 1'b0;
      if_rdata_d  = if_rdata_q;
      d_rdata_d   = d_rdata_q;
      grant_if    = 1'b0;
      grant_d     = 1'b0;
      fetch_first = 1'b0;
`ifdef MEM_ARB_FAIRNESS_EN
      run_cnt_d   = run_cnt_q;
      fetch_first = (run_cnt_q == 4'(MAX_DATA_RUN));
`endif
      case (state_q)
         IDLE, RESP: begin
            // Grants are suppressed while reset is asserted so no handshake
            // completes that the register reset would then discard.
            if (!reset) begin
               if (d_req && !(fetch_first && if_req)) begin
                  grant_d = 1'b1;
               end else if (if_req) begin
                  grant_if = 1'b1;
               end
            end
            if (grant_d) begin
               addr_d  = d_addr;
               wdata_d = d_wdata;
               we_d    = d_we;
               sel_d_d = 1'b1;
               state_d = ACCESS;
            end else if (grant_if) begin
               addr_d  = if_addr;
               we_d    = 1'b0;
               sel_d_d = 1'b0;
               state_d = ACCESS;
            end else begin
               state_d = IDLE;
            end
`ifdef MEM_ARB_FAIRNESS_EN
            if (grant_if || !if_req) begin
               run_cnt_d = '0;
            end else if (grant_d) begin
               run_cnt_d = run_cnt_q + 4'd1;
            end
`endif
         end
         ACCESS: begin
            if (sel_d_q) begin
               d_rdata_d  = mem_rdata;
               d_rvalid_d = 1'b1;
            end else begin
               if_rdata_d  = mem_rdata;
               if_rvalid_d = 1'b1;
            end
            state_d = RESP;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         wdata_q     <= '0;
         we_q        <= 1'b0;
         sel_d_q     <= 1'b0;
         if_rvalid_q <= 1'b0;
         d_rvalid_q  <= 1'b0;
         if_rdata_q  <= '0;
         d_rdata_q   <= '0;
`ifdef MEM_ARB_FAIRNESS_EN
         run_cnt_q   <= '0;
`endif
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         we_q        <= we_d;
         sel_d_q     <= sel_d_d;
         if_rvalid_q <= if_rvalid_d;
         d_rvalid_q  <= d_rvalid_d;
         if_rdata_q  <= if_rdata_d;
         d_rdata_q   <= d_rdata_d;
`ifdef MEM_ARB_FAIRNESS_EN
         run_cnt_q   <= run_cnt_d;
`endif
      end
   end

   // The latched address/data only change on the edge entering ACCESS, so
   // driving them straight out holds the last value in the other states.
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign mem_wen   = (state_q == ACCESS) && we_q && !reset;

   assign if_gnt    = grant_if;
   assign d_gnt     = grant_d;
   assign if_rvalid = if_rvalid_q;
   assign d_rvalid  = d_rvalid_q;
   assign if_rdata  = if_rdata_q;
   assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

   logic        clock = 1'b0;
   logic        reset;
   logic        if_req, d_req, d_we;
   logic [31:0] if_addr, d_addr, d_wdata;
   logic        if_gnt, if_rvalid, d_gnt, d_rvalid, mem_wen;
   logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;

   logic [31:0] mem [0:63];
   int          n_cmp  = 0;
   int          n_fail = 0;

   mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_DATA_RUN(4)) dut (
      .clock(clock), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
      .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
      .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   always #5 clock = ~clock;

   // Bench-side memory: combinational read, write on the rising edge.
   assign mem_rdata = mem[mem_addr[7:2]];
   always @(posedge clock) begin
      if (mem_wen) mem[mem_addr[7:2]] <= mem_wdata;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   typedef struct {
      bit          is_d;
      bit          we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs [6];

   // One isolated transaction from an idle arbiter: gnt at cycle 0,
   // access at cycle 1, rvalid at cycle 2.
   task automatic txn(input vec_t v, input int idx);
      @(negedge clock);
      if (v.is_d) begin
         d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata;
      end else begin
         if_req = 1'b1; if_addr = v.addr;
      end
      #1;
      chk($sformatf("v%0d_gnt", idx), {31'b0, v.is_d ? d_gnt : if_gnt}, 32'd1);
      chk($sformatf("v%0d_other_gnt", idx), {31'b0, v.is_d ? if_gnt : d_gnt}, 32'd0);
      chk($sformatf("v%0d_wen_c0", idx), {31'b0, mem_wen}, 32'd0);
      @(negedge clock);
      d_req = 1'b0; if_req = 1'b0; d_we = 1'b0;
      #1;
      chk($sformatf("v%0d_mem_addr", idx), mem_addr, v.addr);
      chk($sformatf("v%0d_wen_c1", idx), {31'b0, mem_wen}, {31'b0, v.we});
      if (v.we) chk($sformatf("v%0d_mem_wdata", idx), mem_wdata, v.wdata);
      @(negedge clock);
      #1;
      chk($sformatf("v%0d_rvalid", idx), {31'b0, v.is_d ? d_rvalid : if_rvalid}, 32'd1);
      chk($sformatf("v%0d_other_rvalid", idx), {31'b0, v.is_d ? if_rvalid : d_rvalid}, 32'd0);
      chk($sformatf("v%0d_rdata", idx), v.is_d ? d_rdata : if_rdata, v.exp);
      chk($sformatf("v%0d_wen_c2", idx), {31'b0, mem_wen}, 32'd0);
   endtask

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = '0;
      mem[0] = 32'hDD000237;
      mem[1] = 32'h00400093;
      mem[2] = 32'h00800113;
      mem[4] = 32'h0BADF00D;
      mem[9] = 32'hA5A5A5A5;

      vecs[0] = '{is_d: 1'b0, we: 1'b0, addr: 32'h00, wdata: 32'h0,        exp: 32'hDD000237};
      vecs[1] = '{is_d: 1'b1, we: 1'b1, addr: 32'h20, wdata: 32'hCAFEBABE, exp: 32'h00000000};
      vecs[2] = '{is_d: 1'b1, we: 1'b0, addr: 32'h20, wdata: 32'h0,        exp: 32'hCAFEBABE};
      vecs[3] = '{is_d: 1'b0, we: 1'b0, addr: 32'h20, wdata: 32'h0,        exp: 32'hCAFEBABE};
      vecs[4] = '{is_d: 1'b1, we: 1'b1, addr: 32'h24, wdata: 32'h11112222, exp: 32'hA5A5A5A5};
      vecs[5] = '{is_d: 1'b1, we: 1'b0, addr: 32'h24, wdata: 32'h0,        exp: 32'h11112222};

      reset = 1'b1; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
      if_addr = '0; d_addr = '0; d_wdata = '0;

      // Reset held for 3 cycles
      repeat (3) @(negedge clock);
      #1;
      chk("rst_if_gnt", {31'b0, if_gnt}, 32'd0);
      chk("rst_d_gnt", {31'b0, d_gnt}, 32'd0);
      chk("rst_if_rvalid", {31'b0, if_rvalid}, 32'd0);
      chk("rst_d_rvalid", {31'b0, d_rvalid}, 32'd0);
      chk("rst_if_rdata", if_rdata, 32'd0);
      chk("rst_d_rdata", d_rdata, 32'd0);
      chk("rst_mem_addr", mem_addr, 32'd0);
      chk("rst_mem_wen", {31'b0, mem_wen}, 32'd0);
      chk("rst_mem_wdata", mem_wdata, 32'd0);
      reset = 1'b0;

      for (int i = 0; i < 6; i++) txn(vecs[i], i);

      // Simultaneous requests: data first, fetch granted 2 cycles later
      @(negedge clock);
      if_req = 1'b1; if_addr = 32'h00;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20;
      #1;
      chk("sim_c0_d_gnt", {31'b0, d_gnt}, 32'd1);
      chk("sim_c0_if_gnt", {31'b0, if_gnt}, 32'd0);
      @(negedge clock); d_req = 1'b0; #1;
      chk("sim_c1_if_gnt", {31'b0, if_gnt}, 32'd0);
      chk("sim_c1_d_gnt", {31'b0, d_gnt}, 32'd0);
      @(negedge clock); #1;
      chk("sim_c2_d_rvalid", {31'b0, d_rvalid}, 32'd1);
      chk("sim_c2_d_rdata", d_rdata, 32'hCAFEBABE);
      chk("sim_c2_if_rvalid", {31'b0, if_rvalid}, 32'd0);
      chk("sim_c2_if_gnt", {31'b0, if_gnt}, 32'd1);
      @(negedge clock); if_req = 1'b0; #1;
      chk("sim_c3_d_rvalid", {31'b0, d_rvalid}, 32'd0);
      chk("sim_c3_if_rvalid", {31'b0, if_rvalid}, 32'd0);
      @(negedge clock); #1;
      chk("sim_c4_if_rvalid", {31'b0, if_rvalid}, 32'd1);
      chk("sim_c4_if_rdata", if_rdata, 32'hDD000237);
      chk("sim_c4_d_rvalid", {31'b0, d_rvalid}, 32'd0);

      // Back-to-back fetches 0x0, 0x4, 0x8
      for (int c = 0; c < 8; c++) begin
         @(negedge clock);
         if_req  = (c <= 4);
         if_addr = 32'(4 * ((c + 1) / 2));
         #1;
         chk($sformatf("b2b_c%0d_gnt", c), {31'b0, if_gnt},
             {31'b0, (c == 0 || c == 2 || c == 4)});
         chk($sformatf("b2b_c%0d_rvalid", c), {31'b0, if_rvalid},
             {31'b0, (c == 2 || c == 4 || c == 6)});
         if (c == 2) chk("b2b_rdata0", if_rdata, 32'hDD000237);
         if (c == 4) chk("b2b_rdata1", if_rdata, 32'h00400093);
         if (c == 6) chk("b2b_rdata2", if_rdata, 32'h00800113);
      end

      // Continuous competing requests for 20 cycles
      for (int c = 0; c < 20; c++) begin
         bit even, fetch_turn;
         @(negedge clock);
         if_req = 1'b1; if_addr = 32'h00;
         d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20;
         #1;
         even = (c % 2 == 0);
`ifdef MEM_ARB_FAIRNESS_EN
         fetch_turn = (c == 8 || c == 18);
`else
         fetch_turn = 1'b0;
`endif
         chk($sformatf("starve_c%0d_d_gnt", c), {31'b0, d_gnt}, {31'b0, even && !fetch_turn});
         chk($sformatf("starve_c%0d_if_gnt", c), {31'b0, if_gnt}, {31'b0, even && fetch_turn});
      end
      @(negedge clock); if_req = 1'b0; d_req = 1'b0;
      repeat (2) @(negedge clock);

      // Reset during ACCESS of a store: write suppressed, no rvalid
      @(negedge clock);
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h10; d_wdata = 32'h12345678;
      #1;
      chk("rstst_d_gnt", {31'b0, d_gnt}, 32'd1);
      @(negedge clock);
      d_req = 1'b0; d_we = 1'b0; reset = 1'b1;
      #1;
      chk("rstst_wen_forced", {31'b0, mem_wen}, 32'd0);
      @(negedge clock); reset = 1'b0;
      for (int c = 0; c < 4; c++) begin
         #1;
         chk($sformatf("rstst_no_rvalid%0d", c), {31'b0, d_rvalid}, 32'd0);
         @(negedge clock);
      end
      chk("rstst_mem_unchanged", mem[4], 32'h0BADF00D);
      txn('{is_d: 1'b1, we: 1'b0, addr: 32'h10, wdata: 32'h0, exp: 32'h0BADF00D}, 6);

      // Reset during RESP: registered rvalid still seen in that cycle
      @(negedge clock);
      if_req = 1'b1; if_addr = 32'h04;
      #1;
      chk("rstrsp_gnt", {31'b0, if_gnt}, 32'd1);
      @(negedge clock); if_req = 1'b0;
      @(negedge clock); reset = 1'b1; #1;
      chk("rstrsp_rvalid", {31'b0, if_rvalid}, 32'd1);
      chk("rstrsp_rdata", if_rdata, 32'h00400093);
      @(negedge clock); reset = 1'b0; #1;
      chk("rstrsp_rvalid_after", {31'b0, if_rvalid}, 32'd0);
      chk("rstrsp_rdata_after", if_rdata, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single-ported, byte-addressed unified memory (fetch and load/store share one array) between the core's instruction-fetch port and data load/store port. Each requester uses a req/gnt handshake followed by a registered response pulse. The arbiter drives one memory address, write enable and write data, and registers the memory's combinational read word back to the winning requester. It sits between the core pipeline and the memory block, replacing the direct dual-address hookup.

## Interface
Parameters:
- `ADDR_W`, 32: byte address width.
- `DATA_W`, 32: word width; fixed at 4 bytes.
- `MAX_DATA_RUN`, 4: consecutive data grants allowed while fetch waits. Only used with `MEM_ARB_FAIRNESS_EN`. Range 1..15.

Ports:
- `clock`  in  1: single clock, rising edge.
- `reset`  in  1: synchronous, active-high.
- `if_req`  in  1: fetch request; held until `if_gnt`.
- `if_addr`  in  ADDR_W: fetch byte address; stable while `if_req` is high.
- `if_gnt`  out  1: one-cycle grant; `if_addr` is captured on this edge.
- `if_rvalid`  out  1: one-cycle pulse; `if_rdata` is valid.
- `if_rdata`  out  DATA_W: instruction word.
- `d_req`  in  1: data request; held until `d_gnt`.
- `d_we`  in  1: 1 = store, 0 = load.
- `d_addr`  in  ADDR_W: data byte address.
- `d_wdata`  in  DATA_W: store data.
- `d_gnt`  out  1: one-cycle grant.
- `d_rvalid`  out  1: one-cycle pulse. Acknowledges both loads and stores.
- `d_rdata`  out  DATA_W: load data. For a store, this is the pre-write contents.
- `mem_addr`  out  ADDR_W: memory byte address.
- `mem_wen`  out  1: memory write enable. The memory writes on the rising edge.
- `mem_wdata`  out  DATA_W: memory write data.
- `mem_rdata`  in  DATA_W: combinational read of `mem_addr`.

## Operation
- FSM states: `IDLE`, `ACCESS`, `RESP`.
- **IDLE, or RESP with a pending request:** arbitrate. Grant is combinational from the req inputs and the current state.
  - At most one of `if_gnt`/`d_gnt` is high in any cycle.
  - The winner's addr, we and wdata are latched. Next state is `ACCESS`.
  - With no request: IDLE stays IDLE; RESP goes to IDLE.
- **ACCESS:**
  - `mem_addr`, `mem_wdata` and `mem_wen` are driven from the latched values. `mem_wen` = latched `we` AND NOT `reset`.
  - `mem_rdata` is captured into the winner's rdata register at the end of the cycle. Next state is `RESP`.
- **RESP:** the winner's rvalid pulses. Arbitration for the next request runs in the same cycle.
- **Priority (base):** data wins whenever `d_req` and `if_req` are both high.
- Fetch ids and data ids never overlap. Responses are returned in grant order, one outstanding access at a time.
- `mem_addr` holds its last value outside `ACCESS`. `mem_wen` is 0 outside `ACCESS`.
- rdata registers hold their value until the next capture for the same port.
- Addresses pass through unmodified. Alignment is the requester's responsibility.

## Timing
- Reset values: `if_gnt`/`d_gnt` 0 (state is IDLE); `if_rvalid`/`d_rvalid` 0; `if_rdata`/`d_rdata` 0; `mem_addr` 0; `mem_wen` 0; `mem_wdata` 0; `run_cnt` 0.
- Latency: request high in cycle N (arbiter idle) → gnt in N, memory access in N+1, rvalid in N+2.
- Back-to-back throughput: one access per 2 cycles, because the RESP cycle overlaps the next grant.
- A requester may change its req/addr in the cycle after gnt. Dropping req before gnt is allowed; nothing is granted.
- Reset asserted during `ACCESS` with a store: `mem_wen` is forced 0 in that cycle, so the write is suppressed. FSM goes to IDLE and no rvalid is issued.
- Reset asserted during `RESP`: rvalid is still driven in that cycle (it is registered). FSM goes to IDLE.

## Configuration
- `MEM_ARB_FAIRNESS_EN` defined:
  - A 4-bit `run_cnt` increments on each data grant made while `if_req` is high.
  - `run_cnt` clears on any fetch grant, and whenever `if_req` is low in an arbitration cycle.
  - When `run_cnt == MAX_DATA_RUN` and both requests are high, fetch wins.
- `MEM_ARB_FAIRNESS_EN` undefined: fixed data priority, no counter. Fetch can starve under continuous data requests.

## Test plan
- **Reset:** hold `reset` 3 cycles → all outputs 0 and FSM in IDLE. Release, then fetch 0x0 with memory preloaded with 0xDD000237 → `if_gnt` at cycle 0, `if_rvalid` at cycle 2, `if_rdata` = 0xDD000237.
- **Store then load:** store 0xCAFEBABE to 0x20, then load 0x20 → store `d_rvalid` returns the old value 0x00000000. Load returns 0xCAFEBABE. `mem_wen` is high for exactly 1 cycle.
- **Simultaneous requests:** `if_req` and `d_req` raised in the same cycle → `d_gnt` first, `if_gnt` 2 cycles later. Responses arrive in that order with no overlap.
- **Starvation, `MEM_ARB_FAIRNESS_EN` with `MAX_DATA_RUN`=4:** continuous `d_req` plus `if_req` → exactly 4 data grants, then 1 fetch grant, then data resumes. Without the macro, no fetch grant occurs in 20 cycles.
- **Reset mid-store:** assert `reset` during the `ACCESS` cycle of a store of 0x12345678 to 0x10 → address 0x10 is unchanged and `d_rvalid` never pulses.
- **Back-to-back fetches:** fetch 0x0, 0x4, 0x8 held continuously → grants at cycles 0, 2 and 4; rvalids at cycles 2, 4 and 6.
